// File: rtl/calc_pkg.sv
// Shared types and constants for the decimal four-key calculator core.
// States, key codes, status codes and small elaboration-time helpers.
package calc_pkg;

    typedef enum logic [2:0] {
        S_A     = 3'd0,
        S_OP    = 3'd1,
        S_B     = 3'd2,
        S_MUL   = 3'd3,
        S_RES   = 3'd4,
        S_PRINT = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'd10;
    localparam logic [3:0] CMD_SUB = 4'd11;
    localparam logic [3:0] CMD_MUL = 4'd12;
    localparam logic [3:0] CMD_CLR = 4'd13;
    localparam logic [3:0] CMD_EQ  = 4'd14;
    localparam logic [3:0] CMD_BS  = 4'd15;

    localparam logic [1:0] STAT_ERR   = 2'b00;
    localparam logic [1:0] STAT_BUSY  = 2'b01;
    localparam logic [1:0] STAT_READY = 2'b10;
    localparam logic [1:0] STAT_PRINT = 2'b11;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // S_RES is a one-cycle compute step, reported busy like the multiplier.
    function automatic logic [1:0] stat_of(input state_t s);
        case (s)
            S_MUL, S_RES: return STAT_BUSY;
            S_PRINT:      return STAT_PRINT;
            S_ERR:        return STAT_ERR;
            default:      return STAT_READY;
        endcase
    endfunction

endpackage

// File: rtl/calc_digit_printer.sv
// Serialises a binary value into DIGITS BCD digits, least significant first,
// one divide-by-10 per cycle; done_o marks the last digit.
module calc_digit_printer
    import calc_pkg::*;
#(
    parameter  int DIGITS = 8,
    localparam int W      = $clog2(pow10(DIGITS)),
    localparam int PW     = $clog2(DIGITS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_i,
    input  logic [W-1:0]  value_i,
    output logic [3:0]    data_o,
    output logic [PW-1:0] pos_o,
    output logic          done_o
);

    logic [W-1:0]  val_q, val_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          busy_q, busy_d;

    assign done_o = busy_q && (pos_q == PW'(DIGITS - 1));
    assign data_o = busy_q ? 4'(val_q % W'(10)) : 4'd0;
    assign pos_o  = pos_q;

    always_comb begin
        val_d  = val_q;
        pos_d  = pos_q;
        busy_d = busy_q;
        if (load_i) begin
            val_d  = value_i;
            pos_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            val_d = val_q / W'(10);
            if (done_o) begin
                pos_d  = '0;
                busy_d = 1'b0;
            end else begin
                pos_d = pos_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            val_q  <= '0;
            pos_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            pos_q  <= pos_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/calc_core_n.sv
// DIGITS-wide decimal calculator: keypad entry, add/sub/mul in sign+magnitude,
// result chaining, overflow trapping and serial digit output to the display.
module calc_core_n
    import calc_pkg::*;
#(
    parameter  int DIGITS = 8,
    localparam int W      = $clog2(pow10(DIGITS)),
    localparam int PW     = $clog2(DIGITS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic [3:0]    cmd,
    output logic [1:0]    status,
    output logic [3:0]    data,
    output logic [PW-1:0] pos,
    output logic          neg,
    output logic [2:0]    EA
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int MW = $clog2(W);
    localparam logic [2*W-1:0] LIMIT = (2*W)'(pow10(DIGITS));

    state_t         state_q, state_d, ret_q, ret_d;
    logic [W-1:0]   regA_q, regA_d, regB_q, regB_d, entry_q, entry_d;
    logic           signA_q, signA_d, hasres_q, hasres_d, neg_q, neg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     op_q, op_d;
    logic [1:0]     status_q;
    logic [2*W-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [MW-1:0]  mcnt_q, mcnt_d;

    logic           accept, is_digit, is_op, digit_ok, load, sub_b, res_neg, pr_done;
    logic [W-1:0]   base, typed, load_val;
    logic [CW-1:0]  base_cnt, typed_cnt;
    logic [2*W-1:0] res_mag;

    assign accept   = cmd_valid && (status_q == STAT_READY ||
                                    (state_q == S_ERR && cmd == CMD_CLR));
    assign is_digit = (cmd <= 4'd9);
    assign is_op    = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);

    // After a result, typing starts a fresh operand rather than extending it.
    always_comb begin
        base      = hasres_q ? '0 : entry_q;
        base_cnt  = hasres_q ? '0 : cnt_q;
        typed     = base * W'(10) + W'(cmd);
        typed_cnt = (base == '0 && cmd == 4'd0) ? base_cnt : base_cnt + CW'(1);
        digit_ok  = (base_cnt < CW'(DIGITS));
    end

    always_comb begin
        res_mag = '0;
        res_neg = 1'b0;
        sub_b   = (op_q == CMD_SUB);
        if (op_q == CMD_MUL) begin
            res_mag = acc_q;
            res_neg = signA_q;
        end else if (signA_q == sub_b) begin
            res_mag = (2*W)'(regA_q) + (2*W)'(regB_q);
            res_neg = signA_q;
        end else if (regA_q >= regB_q) begin
            res_mag = (2*W)'(regA_q - regB_q);
            res_neg = signA_q;
        end else begin
            res_mag = (2*W)'(regB_q - regA_q);
            res_neg = sub_b;
        end
        if (res_mag == '0) res_neg = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        regA_d   = regA_q;
        signA_d  = signA_q;
        regB_d   = regB_q;
        entry_d  = entry_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hasres_d = hasres_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        mcnt_d   = mcnt_q;
        load     = 1'b0;
        load_val = '0;
        if (accept && cmd == CMD_CLR) begin
            regA_d   = '0;
            signA_d  = 1'b0;
            regB_d   = '0;
            entry_d  = '0;
            cnt_d    = '0;
            op_d     = '0;
            hasres_d = 1'b0;
            neg_d    = 1'b0;
            load     = 1'b1;
            ret_d    = S_A;
            state_d  = S_PRINT;
        end else begin
            unique case (state_q)
                S_A, S_OP, S_B: if (accept) begin
                    if (is_digit) begin
                        if (digit_ok) begin
                            entry_d  = typed;
                            cnt_d    = typed_cnt;
                            hasres_d = 1'b0;
                            neg_d    = 1'b0;
                            load     = 1'b1;
                            load_val = typed;
                            ret_d    = (state_q == S_A) ? S_A : S_B;
                            state_d  = S_PRINT;
                        end
                    end else if (cmd == CMD_BS) begin
                        if (state_q != S_OP) begin
                            entry_d  = base / W'(10);
                            cnt_d    = (base_cnt == '0) ? '0 : base_cnt - CW'(1);
                            hasres_d = 1'b0;
                            neg_d    = 1'b0;
                            load     = 1'b1;
                            load_val = base / W'(10);
                            ret_d    = state_q;
                            state_d  = S_PRINT;
                        end
                    end else if (is_op) begin
                        if (state_q == S_A) begin
                            regA_d   = hasres_q ? regA_q : entry_q;
                            signA_d  = hasres_q & signA_q;
                            op_d     = cmd;
                            entry_d  = '0;
                            cnt_d    = '0;
                            hasres_d = 1'b0;
                            state_d  = S_OP;
                        end else if (state_q == S_OP) begin
                            op_d = cmd;
                        end
                    end else if (cmd == CMD_EQ && state_q != S_A) begin
                        regB_d  = entry_q;
                        entry_d = '0;
                        cnt_d   = '0;
                        if (op_q == CMD_MUL) begin
                            mcand_d  = (2*W)'(regA_q);
                            mplier_d = entry_q;
                            acc_d    = '0;
                            mcnt_d   = '0;
                            state_d  = S_MUL;
                        end else begin
                            state_d = S_RES;
                        end
                    end
                end
                S_MUL: begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    mcnt_d   = mcnt_q + MW'(1);
                    if (mcnt_q == MW'(W - 1)) state_d = S_RES;
                end
                S_RES: begin
                    if (res_mag >= LIMIT) begin
                        state_d = S_ERR;
                    end else begin
                        regA_d   = W'(res_mag);
                        signA_d  = res_neg;
                        entry_d  = '0;
                        cnt_d    = '0;
                        hasres_d = 1'b1;
                        neg_d    = res_neg;
                        load     = 1'b1;
                        load_val = W'(res_mag);
                        ret_d    = S_A;
                        state_d  = S_PRINT;
                    end
                end
                S_PRINT: if (pr_done) state_d = ret_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_A;
            ret_q    <= S_A;
            regA_q   <= '0;
            signA_q  <= 1'b0;
            regB_q   <= '0;
            entry_q  <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            hasres_q <= 1'b0;
            neg_q    <= 1'b0;
            status_q <= STAT_READY;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            regA_q   <= regA_d;
            signA_q  <= signA_d;
            regB_q   <= regB_d;
            entry_q  <= entry_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hasres_q <= hasres_d;
            neg_q    <= neg_d;
            status_q <= stat_of(state_d);
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mcnt_q   <= mcnt_d;
        end
    end

    calc_digit_printer #(.DIGITS(DIGITS)) u_printer (
        .clock   (clock),
        .reset   (reset),
        .load_i  (load),
        .value_i (load_val),
        .data_o  (data),
        .pos_o   (pos),
        .done_o  (pr_done)
    );

    assign status = status_q;
    assign neg    = neg_q;
    assign EA     = state_q;

endmodule
